// File: rtl/life_engine_if.sv
// Control/status bundle for life_engine: the host drives controls and the
// load pattern, the engine returns the grid, generation count and flags.
interface life_engine_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int CW   = 16
);
  logic                 clear;
  logic                 load;
  logic [ROWS*COLS-1:0] gin;
  logic                 start;
  logic                 step;
  logic [CW-1:0]        gen_limit;
  logic [ROWS*COLS-1:0] gout;
  logic [CW-1:0]        gen_count;
  logic                 busy;
  logic                 stable;
  logic                 extinct;
  logic                 done;

  modport master (
    output clear, load, gin, start, step, gen_limit,
    input  gout, gen_count, busy, stable, extinct, done
  );

  modport slave (
    input  clear, load, gin, start, step, gen_limit,
    output gout, gen_count, busy, stable, extinct, done
  );
endinterface

// File: rtl/life_engine.sv
// Cellular-automaton engine: ROWS x COLS grid advanced one generation per
// clock under a birth/survive rule, with IDLE/RUN/HALT sequencing.
module life_engine #(
  parameter int         ROWS    = 8,
  parameter int         COLS    = 8,
  parameter bit         WRAP    = 1'b0,
  parameter logic [8:0] BIRTH   = 9'b000001000,
  parameter logic [8:0] SURVIVE = 9'b000001100,
  parameter int         CW      = 16
) (
  input logic          clk,
  input logic          reset,
  life_engine_if.slave bus
);
  localparam int N = ROWS * COLS;
  // Rules widened so any 4-bit neighbour count indexes in range.
  localparam logic [15:0] BIRTH_LUT   = {7'd0, BIRTH};
  localparam logic [15:0] SURVIVE_LUT = {7'd0, SURVIVE};

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        r_state, w_state_next;
  logic [N-1:0]  r_grid, w_next;
  logic [CW-1:0] r_gen_count, w_count_inc;
  logic          r_stable, r_extinct;
  logic          w_advance, w_stable_next, w_extinct_next;
  logic          w_limit_hit, w_limit_reached;

  genvar gi, gj, gk;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_col
        logic [7:0] w_win;
        logic [1:0] w_s0, w_s1, w_s2, w_s3;
        logic [2:0] w_t0, w_t1;
        logic [3:0] w_cnt;
        for (gk = 0; gk < 9; gk++) begin : g_nb
          if (gk != 4) begin : g_use
            localparam int DR     = gk / 3 - 1;
            localparam int DC     = gk % 3 - 1;
            localparam int RR     = (gi + DR + ROWS) % ROWS;
            localparam int CC     = (gj + DC + COLS) % COLS;
            localparam int BI     = (gk < 4) ? gk : gk - 1;
            localparam bit INSIDE = (gi + DR >= 0) && (gi + DR < ROWS) &&
                                    (gj + DC >= 0) && (gj + DC < COLS);
            if (WRAP || INSIDE) begin : g_live
              assign w_win[BI] = r_grid[RR*COLS+CC];
            end else begin : g_dead
              assign w_win[BI] = 1'b0;
            end
          end
        end
        assign w_s0  = {1'b0, w_win[0]} + {1'b0, w_win[1]};
        assign w_s1  = {1'b0, w_win[2]} + {1'b0, w_win[3]};
        assign w_s2  = {1'b0, w_win[4]} + {1'b0, w_win[5]};
        assign w_s3  = {1'b0, w_win[6]} + {1'b0, w_win[7]};
        assign w_t0  = {1'b0, w_s0} + {1'b0, w_s1};
        assign w_t1  = {1'b0, w_s2} + {1'b0, w_s3};
        assign w_cnt = {1'b0, w_t0} + {1'b0, w_t1};
        assign w_next[gi*COLS+gj] = r_grid[gi*COLS+gj] ? SURVIVE_LUT[w_cnt]
                                                       : BIRTH_LUT[w_cnt];
      end
    end
  endgenerate

  assign w_count_inc     = (&r_gen_count) ? r_gen_count : r_gen_count + CW'(1);
  assign w_stable_next   = (w_next == r_grid);
  assign w_extinct_next  = ~|w_next;
  assign w_limit_hit     = (bus.gen_limit != '0) && (w_count_inc == bus.gen_limit);
  assign w_limit_reached = (bus.gen_limit != '0) && (r_gen_count >= bus.gen_limit);

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    if (bus.clear || bus.load) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            w_state_next = RUN;
          end else if (bus.step && !w_limit_reached) begin
            w_advance = 1'b1;
          end
        end
        RUN: begin
          if (!bus.start) begin
            w_state_next = IDLE;
          end else begin
            w_advance = 1'b1;
            if (w_limit_hit || w_stable_next || w_extinct_next) begin
              w_state_next = HALT;
            end
          end
        end
        HALT:    w_state_next = HALT;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_grid      <= '0;
      r_gen_count <= '0;
      r_stable    <= 1'b0;
      r_extinct   <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (bus.clear) begin
        r_grid      <= '0;
        r_gen_count <= '0;
        r_stable    <= 1'b0;
        r_extinct   <= 1'b1;
      end else if (bus.load) begin
        r_grid      <= bus.gin;
        r_gen_count <= '0;
        r_stable    <= 1'b0;
        r_extinct   <= ~|bus.gin;
      end else if (w_advance) begin
        r_grid      <= w_next;
        r_gen_count <= w_count_inc;
        r_stable    <= w_stable_next;
        r_extinct   <= w_extinct_next;
      end
    end
  end

  assign bus.gout      = r_grid;
  assign bus.gen_count = r_gen_count;
  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == HALT);
  assign bus.stable    = r_stable;
  assign bus.extinct   = r_extinct;
endmodule
